// File: rtl/ccff_chain_loader.sv
// Streams bitstream words LSB-first onto a CHAIN_LEN-flop configuration chain.
// Define CCFF_TAIL_CHECK_EN to build the post-load chain tail check that drives cfg_err.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bits_loaded,
    output logic              cfg_err
);

    localparam int WB_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WB_W-1:0]  LAST_WBIT = WB_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_WORD,
        SHIFT,
        DONE
    } state_t;

    state_t            state, state_nxt;
    logic [WORD_W-1:0] sreg, sreg_nxt;
    logic [WB_W-1:0]   word_bit, word_bit_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              start_accept;

    assign start_accept = (state == IDLE) && start && !abort;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_nxt    = state;
        sreg_nxt     = sreg;
        word_bit_nxt = word_bit;
        cnt_nxt      = cnt;
        case (state)
            IDLE: begin
                if (start_accept) begin
                    state_nxt = WAIT_WORD;
                    cnt_nxt   = '0;
                end
            end
            WAIT_WORD: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (s_valid) begin
                    sreg_nxt     = s_data;
                    word_bit_nxt = '0;
                    state_nxt    = SHIFT;
                end
            end
            SHIFT: begin
                // The chain shifts on this edge regardless of abort, so the count follows it.
                sreg_nxt     = sreg >> 1;
                word_bit_nxt = word_bit + 1'b1;
                cnt_nxt      = cnt + 1'b1;
                if (abort)                      state_nxt = IDLE;
                else if (cnt == LAST_BIT)       state_nxt = DONE;
                else if (word_bit == LAST_WBIT) state_nxt = WAIT_WORD;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!pReset) begin
            state    <= IDLE;
            sreg     <= '0;
            word_bit <= '0;
            cnt      <= '0;
        end else begin
            state    <= state_nxt;
            sreg     <= sreg_nxt;
            word_bit <= word_bit_nxt;
            cnt      <= cnt_nxt;
        end
    end

    // Outputs are pure decodes of registered state: no input-to-output path.
    assign s_ready       = (state == WAIT_WORD);
    assign ccff_shift_en = (state == SHIFT);
    assign ccff_head     = (state == SHIFT) & sreg[0];
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign bits_loaded   = cnt;

`ifdef CCFF_TAIL_CHECK_EN
    logic first_bit;
    logic err_q;

    // After exactly CHAIN_LEN shifts the first bit loaded must sit at the tail.
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            first_bit <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (state == SHIFT && cnt == '0) first_bit <= sreg[0];
            if (start_accept)
                err_q <= 1'b0;
            else if (state == DONE && !abort && ccff_tail != first_bit)
                err_q <= 1'b1;
        end
    end

    assign cfg_err = err_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign cfg_err     = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench for ccff_chain_loader: a 10-flop chain model, expected head bits and
// done events queued by the driver, consumed by an independent monitor.
module tb_ccff_chain_loader;

    localparam int CHAIN_LEN = 10;
    localparam int WORD_W    = 4;
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
`ifdef CCFF_TAIL_CHECK_EN
    localparam int TAIL_CHK = 1;
`else
    localparam int TAIL_CHK = 0;
`endif

    logic              prog_clk = 1'b0;
    logic              pReset   = 1'b0;
    logic              start    = 1'b0;
    logic              abort    = 1'b0;
    logic [WORD_W-1:0] s_data   = '0;
    logic              s_valid  = 1'b0;
    logic              s_ready;
    logic              ccff_head;
    logic              ccff_shift_en;
    logic              ccff_tail;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  bits_loaded;
    logic              cfg_err;

    ccff_chain_loader #(
        .CHAIN_LEN(CHAIN_LEN),
        .WORD_W   (WORD_W),
        .CNT_W    (CNT_W)
    ) dut (
        .prog_clk     (prog_clk),
        .pReset       (pReset),
        .start        (start),
        .abort        (abort),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .ccff_head    (ccff_head),
        .ccff_shift_en(ccff_shift_en),
        .ccff_tail    (ccff_tail),
        .busy         (busy),
        .done         (done),
        .bits_loaded  (bits_loaded),
        .cfg_err      (cfg_err)
    );

    always #5 prog_clk = ~prog_clk;

    // Behavioural chain: chain[0] is the flop nearest the head.
    logic [CHAIN_LEN-1:0] chain = '0;
    bit                   short_chain = 1'b0;
    always @(posedge prog_clk) if (ccff_shift_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
    assign ccff_tail = short_chain ? chain[CHAIN_LEN-2] : chain[CHAIN_LEN-1];

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_bits[$];
    int exp_done[$];
    bit ref_bits[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] fixed_word(input int idx);
        case (idx % 3)
            0:       return 4'h5;
            1:       return 4'hA;
            default: return 4'h3;
        endcase
    endfunction

    // Monitor: every shift cycle must match the next queued bit, every done the queued count.
    initial forever begin
        @(negedge prog_clk);
        if (pReset) begin
            if (ccff_shift_en) begin
                check("shift_en_expected", 32'(ccff_shift_en), 32'(exp_bits.size() != 0));
                if (exp_bits.size() != 0) check("head_bit", 32'(ccff_head), 32'(exp_bits.pop_front()));
            end
            if (done) begin
                check("done_expected", 32'(done), 32'(exp_done.size() != 0));
                if (exp_done.size() != 0) check("done_bits_loaded", 32'(bits_loaded), 32'(exp_done.pop_front()));
            end
        end
    end

    // One load. fixed: words 5,A,3 with stall_max idle cycles before word 2; otherwise random.
    task automatic do_load(input bit fixed, input int stall_max, input int abort_at, input int poke_start_at);
        int                remaining, nshift, stall, widx, cyc;
        bit                aborted, finished;
        logic [WORD_W-1:0] cur;
        logic [CHAIN_LEN-1:0] exp_chain;
        ref_bits.delete();
        exp_bits.delete();
        @(posedge prog_clk); #1;
        start = 1'b1;
        @(posedge prog_clk); #1;
        start     = 1'b0;
        remaining = CHAIN_LEN;
        nshift    = 0;
        widx      = 0;
        cyc       = 0;
        aborted   = 1'b0;
        finished  = 1'b0;
        cur       = fixed ? fixed_word(0) : WORD_W'($urandom);
        stall     = fixed ? 0 : $urandom_range(stall_max, 0);
        for (int budget = 300; budget > 0; budget--) begin
            if (stall > 0) begin
                s_valid = 1'b0;
                if (s_ready) stall--;
            end else begin
                s_valid = 1'b1;
                s_data  = cur;
            end
            start = (cyc == poke_start_at);
            @(negedge prog_clk);
            if (ccff_shift_en) nshift++;
            if (abort_at >= 0 && ccff_shift_en && nshift == abort_at) begin
                abort   = 1'b1;
                aborted = 1'b1;
            end
            if (s_valid && s_ready && !aborted) begin
                if (remaining == 0) begin
                    check("ready_after_last_word", 32'(s_ready), 32'd0);
                end else begin
                    for (int b = 0; b < WORD_W && remaining > 0; b++) begin
                        exp_bits.push_back(cur[b]);
                        ref_bits.push_back(cur[b]);
                        remaining--;
                    end
                    if (remaining == 0) exp_done.push_back(CHAIN_LEN);
                    widx++;
                    cur   = fixed ? fixed_word(widx) : WORD_W'($urandom);
                    stall = fixed ? ((widx == 1) ? stall_max : 0) : $urandom_range(stall_max, 0);
                end
            end
            @(posedge prog_clk); #1;
            abort = 1'b0;
            start = 1'b0;
            cyc++;
            if (aborted) begin
                check("abort_idle_next_cycle", 32'(busy), 32'd0);
                check("abort_shift_en_drops", 32'(ccff_shift_en), 32'd0);
                finished = 1'b1;
                break;
            end
            if (!busy) begin
                finished = 1'b1;
                break;
            end
        end
        s_valid = 1'b0;
        check("load_terminates", 32'(finished), 32'd1);
        if (aborted) begin
            check("abort_bits_loaded", 32'(bits_loaded), 32'(abort_at));
            exp_bits.delete();
        end else begin
            check("bits_loaded_final", 32'(bits_loaded), 32'(CHAIN_LEN));
            check("shift_cycles", 32'(nshift), 32'(CHAIN_LEN));
            check("all_bits_shifted", 32'(exp_bits.size()), 32'd0);
            check("done_pulsed", 32'(exp_done.size()), 32'd0);
            exp_chain = '0;
            foreach (ref_bits[i]) exp_chain[CHAIN_LEN-1-i] = ref_bits[i];
            check("chain_content", 32'(chain), 32'(exp_chain));
        end
    endtask

    task automatic idle_start_abort(input int exp_cnt, input int exp_err);
        @(posedge prog_clk); #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", 32'(busy), 32'd0);
        check("start_abort_ready", 32'(s_ready), 32'd0);
        check("start_abort_bits", 32'(bits_loaded), 32'(exp_cnt));
        check("start_abort_cfg_err", 32'(cfg_err), 32'(exp_err));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [CHAIN_LEN-1:0] snap;
        bit got_shift;

        #2;
        check("reset_s_ready", 32'(s_ready), 32'd0);
        check("reset_head", 32'(ccff_head), 32'd0);
        check("reset_shift_en", 32'(ccff_shift_en), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_bits_loaded", 32'(bits_loaded), 32'd0);
        check("reset_cfg_err", 32'(cfg_err), 32'd0);
        #20 pReset = 1'b1;

        // Basic load: head 1,0,1,0,0,1,0,1,1,1.
        do_load(1'b1, 0, -1, -1);
        check("basic_chain_sequence", 32'(chain), 32'(10'b1010010111));
        check("basic_cfg_err", 32'(cfg_err), 32'd0);

        // Stalled source before word 2.
        chain = '0;
        do_load(1'b1, 5, -1, -1);
        check("stalled_chain_sequence", 32'(chain), 32'(10'b1010010111));

        idle_start_abort(CHAIN_LEN, 0);

        // Abort after six shifts, then a full load.
        do_load(1'b0, 3, 6, -1);
        do_load(1'b0, 3, -1, -1);

        // Start pulsed while busy must be ignored.
        do_load(1'b0, 2, -1, 3);

        // Tail check: one flop short makes the tail disagree with the first bit.
        short_chain = 1'b1;
        do_load(1'b1, 0, -1, -1);
        check("short_chain_cfg_err", 32'(cfg_err), 32'(TAIL_CHK));
        idle_start_abort(CHAIN_LEN, TAIL_CHK);
        short_chain = 1'b0;
        do_load(1'b1, 0, -1, -1);
        check("cfg_err_cleared_by_start", 32'(cfg_err), 32'd0);

        // Asynchronous reset in the middle of SHIFT.
        exp_bits.delete();
        exp_bits.push_back(1'b1);
        exp_bits.push_back(1'b0);
        exp_bits.push_back(1'b0);
        exp_bits.push_back(1'b1);
        @(posedge prog_clk); #1;
        start = 1'b1;
        @(posedge prog_clk); #1;
        start   = 1'b0;
        s_valid = 1'b1;
        s_data  = 4'h9;
        got_shift = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge prog_clk); #1;
            if (ccff_shift_en) begin
                got_shift = 1'b1;
                break;
            end
        end
        check("reset_test_reached_shift", 32'(got_shift), 32'd1);
        @(negedge prog_clk); #2;
        snap   = chain;
        pReset = 1'b0;
        #1;
        check("midreset_s_ready", 32'(s_ready), 32'd0);
        check("midreset_head", 32'(ccff_head), 32'd0);
        check("midreset_shift_en", 32'(ccff_shift_en), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_bits_loaded", 32'(bits_loaded), 32'd0);
        check("midreset_cfg_err", 32'(cfg_err), 32'd0);
        @(posedge prog_clk); #1;
        check("midreset_no_chain_shift", 32'(chain), 32'(snap));
        s_valid = 1'b0;
        exp_bits.delete();
        @(negedge prog_clk);
        pReset = 1'b1;

        // Randomized loads with random stalls.
        for (int n = 0; n < 6; n++) do_load(1'b0, 6, -1, -1);

        repeat (3) @(posedge prog_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Programming controller for the tile configuration chain (ccff_head to ccff_tail daisy chain through the grid/logical-tile config flops).
- Accepts bitstream words over a valid/ready stream and serializes exactly CHAIN_LEN bits onto ccff_head, one per prog_clk while ccff_shift_en is high.
- Reports busy, done and bit count, and optionally checks the chain tail after loading.
- Sits between the bitstream source (JTAG/SPI/SoC bus bridge) and the fabric's configuration chain.

Parameters:
- CHAIN_LEN, 1024, number of configuration flops in the chain (>=2).
- WORD_W, 8, bitstream word width in bits (>=1).
- CNT_W, $clog2(CHAIN_LEN+1), width of bits_loaded.

Ports:
- prog_clk  input  1  programming clock; all state advances on its rising edge.
- pReset  input  1  asynchronous, active-low reset (low = reset).
- start  input  1  1-cycle request to begin a load; honoured only in IDLE.
- abort  input  1  terminates any load in progress.
- s_data  input  WORD_W  bitstream word; bit 0 is shifted first.
- s_valid  input  1  s_data valid.
- s_ready  output  1  controller accepts s_data this cycle.
- ccff_head  output  1  serial config bit to the chain head.
- ccff_shift_en  output  1  chain shifts on the prog_clk edge ending a cycle where this is 1.
- ccff_tail  input  1  chain tail bit, used only by the optional check.
- busy  output  1  high in any state other than IDLE.
- done  output  1  1-cycle pulse when CHAIN_LEN bits have been shifted.
- bits_loaded  output  CNT_W  bits shifted so far in the current or last load.
- cfg_err  output  1  sticky tail-check failure (optional feature only).

Behaviour:
- Reset (pReset=0, asynchronous): state=IDLE; s_ready=0, ccff_head=0, ccff_shift_en=0, busy=0, done=0, bits_loaded=0, cfg_err=0; shift register and counters are cleared.
- Output timing: all outputs decode from registers only. There is no combinational path from any input to any output.
- States: IDLE, WAIT_WORD, SHIFT, DONE.
- IDLE: start=1 and abort=0 -> WAIT_WORD. On this transition bits_loaded clears to 0 and cfg_err clears.
- WAIT_WORD: s_ready=1. On s_valid&s_ready, s_data loads into the shift register, word_bit clears to 0, and the state goes to SHIFT. With no valid word, stay in WAIT_WORD indefinitely; ccff_shift_en stays 0.
- SHIFT: s_ready=0, ccff_shift_en=1, ccff_head=sreg[0]. Each cycle: sreg>>=1, word_bit++, bits_loaded++.
  - If bits_loaded+1==CHAIN_LEN -> DONE.
  - Else if word_bit+1==WORD_W -> WAIT_WORD.
  - Else stay in SHIFT.
- Throughput: one word per WORD_W+1 cycles (one handshake cycle plus WORD_W shift cycles).
- Final word: bits beyond CHAIN_LEN are discarded. No further s_ready is issued in that load.
- DONE: done=1 for exactly one cycle, ccff_shift_en=0, then IDLE. bits_loaded holds CHAIN_LEN until the next start.
- abort=1 in WAIT_WORD, SHIFT or DONE: next state is IDLE, ccff_shift_en drops the following cycle, and done is not pulsed. bits_loaded holds the partial count; the chain content is undefined.
- abort in IDLE: no effect. start together with abort in IDLE: abort wins and the state stays IDLE.
- start while busy: ignored.
- Reset mid-load: immediate return to IDLE with reset values. No shift occurs at the next prog_clk edge.
- bits_loaded never exceeds CHAIN_LEN and never wraps.

Optional Feature:
- Macro: CCFF_TAIL_CHECK_EN.
- When defined:
  - The first bit shifted in each load is captured.
  - In the DONE cycle, ccff_tail is sampled. After exactly CHAIN_LEN shifts it must equal the captured bit.
  - On mismatch, cfg_err is set and stays sticky until the next accepted start or reset. done still pulses.
- When undefined: cfg_err is tied to 0 and ccff_tail is unused. No capture logic is built.

Test Plan (CHAIN_LEN=10, WORD_W=4, behavioural 10-flop chain model on prog_clk gated by ccff_shift_en):
- Basic load: start, then words 0x5, 0xA, 0x3 with s_valid always high -> head sequence 1,0,1,0,0,1,0,1,1,1. Exactly 10 shift_en cycles. The last two bits of 0x3 are dropped. done pulses once; bits_loaded=10; the chain holds this sequence.
- Stalled source: s_valid low for 5 cycles before word 2 -> no shift_en during the stall. The final chain content is identical to the basic load.
- Abort: abort asserted after 6 shifts -> IDLE next cycle, no done, bits_loaded=6, busy=0. A subsequent start and full load succeeds.
- Start while busy and start+abort in IDLE: both ignored; state and outputs unchanged.
- Async reset mid-SHIFT: pReset low between clock edges -> all outputs immediately at reset values. No further chain shifts occur.
- CCFF_TAIL_CHECK_EN, pass and fail:
  - Correct chain model -> cfg_err=0.
  - Chain model forced one flop short (9 flops) -> tail at DONE mismatches, so cfg_err=1 and stays 1 until the next start.
